// File: rtl/mux_width_chan_pkg.sv
// mux_width_chan_pkg
// Shared constants and helpers for the registered channel multiplexer.
//   MUX_WIDTH_DEF / MUX_CHANNELS_DEF / MUX_SEL_LENGTH_DEF : default parameters
//   min_sel_length(channels) : smallest sel width able to address every channel
package mux_width_chan_pkg;

  localparam int MUX_WIDTH_DEF      = 3;
  localparam int MUX_CHANNELS_DEF   = 8;
  localparam int MUX_SEL_LENGTH_DEF = 4;

  // Smallest n with 2**n >= channels (never below 1).
  function automatic int min_sel_length(input int channels);
    int n;
    n = 1;
    while ((1 << n) < channels) n = n + 1;
    return n;
  endfunction

endpackage

// File: rtl/mux_width_chan_comb.sv
// mux_width_chan_comb
// Purely combinational field selector over a flat packed bus.
//   in_bus       : CHANNELS packed fields of WIDTH bits, channel 0 in the LSBs
//   sel          : unsigned channel index
//   field        : selected channel, all zeros when sel is out of range
//   out_of_range : sel >= CHANNELS
module mux_width_chan_comb
  import mux_width_chan_pkg::*;
#(
  parameter int WIDTH      = MUX_WIDTH_DEF,
  parameter int CHANNELS   = MUX_CHANNELS_DEF,
  parameter int SEL_LENGTH = MUX_SEL_LENGTH_DEF
) (
  input  logic [WIDTH*CHANNELS-1:0] in_bus,
  input  logic [SEL_LENGTH-1:0]     sel,
  output logic [WIDTH-1:0]          field,
  output logic                      out_of_range
);

  // One extra bit so CHANNELS itself is representable when 2**SEL_LENGTH == CHANNELS.
  localparam logic [SEL_LENGTH:0] CHAN_LIMIT = (SEL_LENGTH + 1)'(CHANNELS);

  assign out_of_range = ({1'b0, sel} >= CHAN_LIMIT);

  // Explicit compare-and-pick loop: an out-of-range index never produces an
  // undefined part-select, it simply matches nothing and leaves zeros.
  always_comb begin
    field = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if ({1'b0, sel} == (SEL_LENGTH + 1)'(k)) begin
        field = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_width_chan.sv
// mux_width_chan
// Registered N-channel, W-bit multiplexer with one cycle of latency.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (wins over in_valid)
//   in_bus    : CHANNELS packed fields of WIDTH bits, channel 0 in the LSBs
//   sel       : unsigned channel index
//   in_valid  : qualifies in_bus/sel for capture
//   out       : selected channel, registered; holds while in_valid=0
//   out_valid : out was updated on the previous edge from a valid input
//   sel_err   : last captured sel was >= CHANNELS (only with MUX_WIDTH_CHAN_SEL_ERR_EN)
// Handshake: in_valid/out_valid form a valid-only stream with no ready; every
// cycle with in_valid=1 is captured and yields out_valid=1 on the next cycle.
// Optional feature macro: MUX_WIDTH_CHAN_SEL_ERR_EN adds the sel_err port/register.
module mux_width_chan
  import mux_width_chan_pkg::*;
#(
  parameter int WIDTH      = MUX_WIDTH_DEF,
  parameter int CHANNELS   = MUX_CHANNELS_DEF,
  parameter int SEL_LENGTH = MUX_SEL_LENGTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] in_bus,
  input  logic [SEL_LENGTH-1:0]     sel,
  input  logic                      in_valid,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid
`ifdef MUX_WIDTH_CHAN_SEL_ERR_EN
  ,
  output logic                      sel_err
`endif
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("mux_width_chan: WIDTH must be >= 1");
    end
    if (CHANNELS < 2) begin : g_bad_channels
      $error("mux_width_chan: CHANNELS must be >= 2");
    end
    if (SEL_LENGTH < min_sel_length(CHANNELS)) begin : g_bad_sel
      $error("mux_width_chan: SEL_LENGTH too narrow for CHANNELS");
    end
  endgenerate

  logic [WIDTH-1:0] field;
  logic             out_of_range;

  mux_width_chan_comb #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .SEL_LENGTH (SEL_LENGTH)
  ) u_comb (
    .in_bus       (in_bus),
    .sel          (sel),
    .field        (field),
    .out_of_range (out_of_range)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      // The selector already zeroes bad indices; gating here keeps the
      // zero-on-error rule local to the register stage as well.
      out       <= out_of_range ? '0 : field;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_WIDTH_CHAN_SEL_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (in_valid) begin
      sel_err <= out_of_range;
    end
  end
`endif

endmodule

// File: tb/tb_mux_width_chan.sv
// tb_mux_width_chan
// Directed bench for mux_width_chan (WIDTH=3, CHANNELS=8, SEL_LENGTH=4).
// A behavioural model updated on every rising edge is compared against the
// DUT on every falling edge; each directed step also checks hand-computed values.
module tb_mux_width_chan;

  localparam int WIDTH      = 3;
  localparam int CHANNELS   = 8;
  localparam int SEL_LENGTH = 4;
  localparam int BUS_W      = WIDTH * CHANNELS;

  // ---------------- clock / reset ----------------
  logic                  clk;
  logic                  rst_n;
  logic [BUS_W-1:0]      in_bus;
  logic [SEL_LENGTH-1:0] sel;
  logic                  in_valid;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
`ifdef MUX_WIDTH_CHAN_SEL_ERR_EN
  logic                  sel_err;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_width_chan #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .SEL_LENGTH (SEL_LENGTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
`ifdef MUX_WIDTH_CHAN_SEL_ERR_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_out;
  logic             m_valid;
  logic             m_err;
  logic             model_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_out   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else if (in_valid) begin
      if (int'(sel) < CHANNELS) begin
        m_out = WIDTH'(in_bus >> (int'(sel) * WIDTH));
        m_err = 1'b0;
      end else begin
        m_out = '0;
        m_err = 1'b1;
      end
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    // Model is only meaningful once a reset edge has defined the state.
    if (!rst_n) model_ok = 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_out", 32'(out), 32'(m_out));
      chk("model_valid", 32'(out_valid), 32'(m_valid));
`ifdef MUX_WIDTH_CHAN_SEL_ERR_EN
      chk("model_sel_err", 32'(sel_err), 32'(m_err));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic [BUS_W-1:0] bus,
                      input logic [SEL_LENGTH-1:0] s);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    in_bus   = bus;
    sel      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [WIDTH-1:0] exp_out,
                     input logic exp_valid, input logic exp_err);
    chk({name, "_out"}, 32'(out), 32'(exp_out));
    chk({name, "_valid"}, 32'(out_valid), 32'(exp_valid));
`ifdef MUX_WIDTH_CHAN_SEL_ERR_EN
    chk({name, "_sel_err"}, 32'(sel_err), 32'(exp_err));
`else
    if (exp_err) begin end
`endif
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [BUS_W-1:0] octal_bus;
    rst_n = 1'b0; in_valid = 1'b1; in_bus = '1; sel = '0;

    // reset wins over in_valid
    step(1'b0, 1'b1, 24'hFFFFFF, 4'd0);
    step(1'b0, 1'b1, 24'hFFFFFF, 4'd0);
    lit("reset", 3'b000, 1'b0, 1'b0);

    // walking pattern on channel 2
    step(1'b1, 1'b1, 24'h000005, 4'd2); lit("walk0", 3'b000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000028, 4'd2); lit("walk1", 3'b000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000140, 4'd2); lit("walk2", 3'b101, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000A00, 4'd2); lit("walk3", 3'b000, 1'b1, 1'b0);

    // shift back, channel 0
    step(1'b1, 1'b1, 24'h000005, 4'd0); lit("ch0_0", 3'b101, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000028, 4'd0); lit("ch0_1", 3'b000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000140, 4'd0); lit("ch0_2", 3'b000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000A00, 4'd0); lit("ch0_3", 3'b000, 1'b1, 1'b0);

    // top channel
    step(1'b1, 1'b1, 24'hA00000, 4'd7); lit("top_a", 3'b101, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'hE00000, 4'd7); lit("top_e", 3'b111, 1'b1, 1'b0);

    // out-of-range indices
    step(1'b1, 1'b1, 24'hFFFFFF, 4'd8);  lit("oor8", 3'b000, 1'b1, 1'b1);
    step(1'b1, 1'b1, 24'hFFFFFF, 4'd15); lit("oor15", 3'b000, 1'b1, 1'b1);
    step(1'b1, 1'b1, 24'hFFFFFF, 4'd1);  lit("back_in", 3'b111, 1'b1, 1'b0);

    // sweep: channel k holds value k, so in-range sel returns sel itself
    octal_bus = 24'o76543210;
    for (int s = 0; s < 16; s++) begin
      step(1'b1, 1'b1, octal_bus, 4'(s));
      lit("sweep", (s < CHANNELS) ? 3'(s) : 3'b000, 1'b1, (s >= CHANNELS));
    end

    // sel_err and out hold while idle
    step(1'b1, 1'b1, 24'hFFFFFF, 4'd9); lit("err_set", 3'b000, 1'b1, 1'b1);
    step(1'b1, 1'b0, 24'h123456, 4'd2); lit("err_hold", 3'b000, 1'b0, 1'b1);

    // hold
    step(1'b1, 1'b1, 24'h000005, 4'd0); lit("hold_cap", 3'b101, 1'b1, 1'b0);
    step(1'b1, 1'b0, 24'h123456, 4'd2); lit("hold0", 3'b101, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'hABCDEF, 4'd3); lit("hold1", 3'b101, 1'b0, 1'b0);

    // mid-stream reset discards the pending valid input
    step(1'b0, 1'b1, 24'hFFFFFF, 4'd1); lit("mid_reset", 3'b000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'hE00000, 4'd7); lit("post_reset", 3'b111, 1'b1, 1'b0);
    step(1'b1, 1'b0, 24'h000000, 4'd0); lit("post_idle", 3'b111, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
